ocr_sequencer: RTL
==================

OCR_SEQUENCER -- requirements
Module: ocr_sequencer

Interface
REQ-001 Parameter IMG_BYTES, default 113: number of bytes in one packed 30x30 image frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum INFER duration in cycles before error.
REQ-003 Parameter FULL_WAIT_CYCLES, default 4: maximum WAIT_FULL duration in cycles before error.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx_valid  in  1  byte available from the host byte interface.
REQ-007 rx_data  in  8  host byte.
REQ-008 rx_ready  out  1  sequencer accepts the byte this cycle.
REQ-009 clear_req  in  1  host abort/clear pulse.
REQ-010 buf_clear  out  1  clear strobe to the image buffer.
REQ-011 buf_write_request  out  1  write strobe to the image buffer.
REQ-012 buf_data  out  8  write data to the image buffer.
REQ-013 buf_write_ready  in  1  image buffer has space.
REQ-014 buf_full  in  1  image buffer holds IMG_BYTES bytes.
REQ-015 bnn_start  out  1  single-cycle inference start pulse.
REQ-016 bnn_done  in  1  inference complete.
REQ-017 bnn_result  in  4  recognised class; valid while bnn_done=1.
REQ-018 result_valid  out  1  result register holds an unconsumed result.
REQ-019 result  out  4  latched class.
REQ-020 result_ack  in  1  host consumed the result.
REQ-021 busy  out  1  high in WAIT_FULL and INFER.
REQ-022 error  out  1  high in ERROR.
REQ-023 state_dbg  out  3  current state encoding.

Function
REQ-024 States SHALL be CLEAR=0, LOAD=1, WAIT_FULL=2, INFER=3, RESULT=4, ERROR=5.
REQ-025 CLEAR SHALL last exactly one cycle: buf_clear=1, byte counter zeroed, then go to LOAD.
REQ-026 In LOAD: rx_ready=buf_write_ready; buf_write_request=rx_valid&rx_ready (combinational); buf_data=rx_data.
REQ-027 Outside LOAD: rx_ready=0 and buf_write_request=0; bytes presented there are not consumed.
REQ-028 Each accepted byte SHALL increment an 8-bit counter; the cycle it accepts byte number IMG_BYTES, LOAD SHALL go to WAIT_FULL.
REQ-029 WAIT_FULL: buf_full=1 -> INFER; FULL_WAIT_CYCLES cycles without buf_full -> ERROR.
REQ-030 bnn_start SHALL be high exactly one cycle: the first cycle of each INFER visit.
REQ-031 INFER: bnn_done=1 -> latch bnn_result into result, go to RESULT; TIMEOUT_CYCLES cycles without done -> ERROR.
REQ-032 The timeout counter SHALL reset on every entry to WAIT_FULL or INFER.
REQ-033 bnn_done outside INFER SHALL be ignored, with result unchanged.
REQ-034 RESULT: result_valid=1; result_ack=1 -> CLEAR; result SHALL hold its value until the next latch.
REQ-035 ERROR: error=1, held until clear_req.
REQ-036 clear_req=1 in any state SHALL force CLEAR next cycle and SHALL override every other transition in the same cycle, including a byte accept, bnn_done and result_ack.
REQ-037 A byte accepted in the same cycle as clear_req SHALL still be written to the buffer; the buffer clear in the following cycle discards it.
REQ-038 result_ack outside RESULT SHALL be ignored.

Reset
REQ-039 rst=1 SHALL force CLEAR next cycle and clear the byte counter, timeout counter and result register.
REQ-040 After rst, all outputs SHALL be 0 except buf_clear=1 and state_dbg=0 (CLEAR).
REQ-041 rst SHALL take priority over clear_req and all inputs, including mid-load and mid-inference.

Verification
REQ-042 Reset, then 113 bytes 0x00..0x70 with rx_valid held and buf_write_ready=1 -> 113 writes in 113 consecutive cycles, then WAIT_FULL; buf_full=1 -> one bnn_start pulse; bnn_done with result 7 -> result=7, result_valid=1; result_ack -> one buf_clear pulse, then LOAD.
REQ-043 Drop buf_write_ready for 5 cycles mid-frame -> rx_ready=0 and no writes during that window; the frame still completes after exactly 113 accepts.
REQ-044 INFER with bnn_done never asserted -> error=1 exactly 4096 cycles after the bnn_start cycle; clear_req -> CLEAR, then LOAD, error=0.
REQ-045 clear_req after 50 bytes -> buf_clear next cycle; a subsequent full frame needs 113 fresh bytes.
REQ-046 clear_req and bnn_done in the same cycle -> CLEAR, result unchanged, result_valid=0.
REQ-047 rst during INFER -> next cycle CLEAR, result=0, no further bnn_start until a new 113-byte frame.

Source files
------------

// File: rtl/ocr_sequencer.sv
// ocr_sequencer: loads one packed 30x30 image from a host byte stream into the
// image buffer, launches the BNN, and holds the recognised class until the host
// acknowledges it. Stalls in WAIT_FULL or INFER end in a sticky ERROR state.
module ocr_sequencer #(
    parameter int IMG_BYTES        = 113,
    parameter int TIMEOUT_CYCLES   = 4096,
    parameter int FULL_WAIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    // host byte interface
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       clear_req,
    // image buffer
    output logic       buf_clear,
    output logic       buf_write_request,
    output logic [7:0] buf_data,
    input  logic       buf_write_ready,
    input  logic       buf_full,
    // BNN core
    output logic       bnn_start,
    input  logic       bnn_done,
    input  logic [3:0] bnn_result,
    // result / status
    output logic       result_valid,
    output logic [3:0] result,
    input  logic       result_ack,
    output logic       busy,
    output logic       error,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_CLEAR     = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_FULL = 3'd2,
        S_INFER     = 3'd3,
        S_RESULT    = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    // One shared watchdog counter serves both WAIT_FULL and INFER, so it is
    // sized for the longer of the two limits.
    localparam int TMO_MAX = (TIMEOUT_CYCLES > FULL_WAIT_CYCLES) ? TIMEOUT_CYCLES
                                                                  : FULL_WAIT_CYCLES;
    localparam int TMO_W   = $clog2(TMO_MAX + 1);

    localparam logic [7:0]       LAST_BYTE  = 8'(IMG_BYTES - 1);
    localparam logic [TMO_W-1:0] FULL_LAST  = TMO_W'(FULL_WAIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] INFER_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_byte_cnt;
    logic [TMO_W-1:0] r_tmo;
    logic [3:0]       r_result;

    logic             w_accept;
    logic             w_last_byte;
    logic             w_full_expired;
    logic             w_infer_expired;
    logic             w_timed_state;
    logic             w_result_latch;

    // A byte is taken only in LOAD, when the host offers one and the buffer has room.
    assign w_accept        = (r_state == S_LOAD) && rx_valid && buf_write_ready;
    assign w_last_byte     = w_accept && (r_byte_cnt == LAST_BYTE);
    assign w_full_expired  = (r_tmo == FULL_LAST);
    assign w_infer_expired = (r_tmo == INFER_LAST);
    assign w_timed_state   = (r_state == S_WAIT_FULL) || (r_state == S_INFER);

    // clear_req wins over a simultaneous bnn_done, so the result is left untouched.
    assign w_result_latch  = (r_state == S_INFER) && bnn_done && !clear_req;

    // State register; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a host clear overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (clear_req) begin
            w_state_nxt = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    w_state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (w_last_byte) begin
                        w_state_nxt = S_WAIT_FULL;
                    end
                end
                S_WAIT_FULL: begin
                    if (buf_full) begin
                        w_state_nxt = S_INFER;
                    end else if (w_full_expired) begin
                        w_state_nxt = S_ERROR;
                    end
                end
                S_INFER: begin
                    if (bnn_done) begin
                        w_state_nxt = S_RESULT;
                    end else if (w_infer_expired) begin
                        w_state_nxt = S_ERROR;
                    end
                end
                S_RESULT: begin
                    if (result_ack) begin
                        w_state_nxt = S_CLEAR;
                    end
                end
                S_ERROR: begin
                    w_state_nxt = S_ERROR;
                end
                default: begin
                    w_state_nxt = S_CLEAR;
                end
            endcase
        end
    end

    // Output decode; the LOAD handshake is combinational so a byte moves every cycle.
    always_comb begin
        rx_ready          = 1'b0;
        buf_write_request = 1'b0;
        buf_clear         = 1'b0;
        bnn_start         = 1'b0;
        result_valid      = 1'b0;
        busy              = 1'b0;
        error             = 1'b0;
        case (r_state)
            S_CLEAR: begin
                buf_clear = 1'b1;
            end
            S_LOAD: begin
                rx_ready          = buf_write_ready;
                buf_write_request = rx_valid && buf_write_ready;
            end
            S_WAIT_FULL: begin
                busy = 1'b1;
            end
            S_INFER: begin
                busy = 1'b1;
                // The watchdog is zero only on the first cycle of an INFER visit.
                bnn_start = (r_tmo == '0);
            end
            S_RESULT: begin
                result_valid = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                buf_clear = 1'b0;
            end
        endcase
    end

    assign buf_data  = rx_data;
    assign result    = r_result;
    assign state_dbg = r_state;

    // Byte counter: restarted by CLEAR, advanced on every accepted byte.
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_CLEAR)) begin
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
        end
    end

    // Watchdog: zeroed on every state change so each WAIT_FULL/INFER visit starts fresh.
    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt != r_state) || !w_timed_state) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // Result register: captures the class on bnn_done in INFER, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_result_latch) begin
            r_result <= bnn_result;
        end
    end

endmodule
